// File: rtl/wave_gen.sv
// Phase-accumulator waveform generator: sine (parabolic), triangle, sawtooth,
// square and DC midscale samples, with waveform changes deferred to phase wrap.
module wave_gen #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [2:0]         wave_sel,
  input  logic [DATA_W-1:0]  duty,
  output logic [DATA_W-1:0]  wave_out,
  output logic               wave_valid,
  output logic               cycle_start
);

  localparam int PROD_W = 2 * (DATA_W - 1);
  localparam logic [DATA_W-1:0] MID_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_VAL  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO_VAL = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE_VAL  = {{(DATA_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] SEL_SINE = 3'd0;
  localparam logic [2:0] SEL_TRI  = 3'd1;
  localparam logic [2:0] SEL_SAW  = 3'd2;
  localparam logic [2:0] SEL_SQR  = 3'd3;

  logic [PHASE_W-1:0] acc_r;
  logic               wrap_r;
  logic [2:0]         active_sel_r;
  logic [PHASE_W:0]   sum_s;

  logic [DATA_W-1:0]  p1_r;
  logic [2:0]         sel1_r;
  logic [DATA_W-1:0]  duty1_r;
  logic               wrap1_r;
  logic               en1_r;

  logic [DATA_W-2:0]  x_s;
  logic [PROD_W-1:0]  prod_s;
  logic [DATA_W-1:0]  q_s;
  logic [DATA_W-1:0]  tri_s;
  logic [DATA_W-1:0]  sine_s;
  logic [DATA_W-1:0]  sample_s;

  // The extra MSB of the sum is the wrap carry.
  assign sum_s = {1'b0, acc_r} + {1'b0, freq_word};

  // Phase accumulator; the waveform code is only latched at wrap while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r        <= {PHASE_W{1'b0}};
      wrap_r       <= 1'b0;
      active_sel_r <= 3'd0;
    end else if (en) begin
      acc_r  <= sum_s[PHASE_W-1:0];
      wrap_r <= sum_s[PHASE_W];
      if (sum_s[PHASE_W]) begin
        active_sel_r <= wave_sel;
      end else begin
        active_sel_r <= active_sel_r;
      end
    end else begin
      acc_r        <= acc_r;
      wrap_r       <= 1'b0;
      active_sel_r <= wave_sel;
    end
  end

  // Stage 1: capture phase index and everything the shaper needs alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_r    <= ZERO_VAL;
      sel1_r  <= 3'd0;
      duty1_r <= ZERO_VAL;
      wrap1_r <= 1'b0;
      en1_r   <= 1'b0;
    end else begin
      p1_r    <= acc_r[PHASE_W-1 -: DATA_W];
      sel1_r  <= active_sel_r;
      duty1_r <= duty;
      wrap1_r <= wrap_r;
      en1_r   <= en;
    end
  end

  // Half-period parabola x*(M-1-x); M-1-x is just the bitwise complement of x.
  always_comb begin
    x_s    = p1_r[DATA_W-2:0];
    prod_s = {{(DATA_W-1){1'b0}}, x_s} * {{(DATA_W-1){1'b0}}, ~x_s};
    q_s    = DATA_W'(prod_s >> (DATA_W - 3));
    tri_s  = {x_s, 1'b0};
    if (p1_r[DATA_W-1]) begin
      sine_s = MID_VAL - ONE_VAL - q_s;
      tri_s  = ~tri_s;
    end else begin
      sine_s = MID_VAL + q_s;
    end
  end

  // Waveform selection; unused codes give DC midscale.
  always_comb begin
    sample_s = MID_VAL;
    case (sel1_r)
      SEL_SINE: sample_s = sine_s;
      SEL_TRI:  sample_s = tri_s;
      SEL_SAW:  sample_s = p1_r;
      SEL_SQR: begin
        if (p1_r < duty1_r) begin
          sample_s = MAX_VAL;
        end else begin
          sample_s = ZERO_VAL;
        end
      end
      default:  sample_s = MID_VAL;
    endcase
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wave_out    <= ZERO_VAL;
      wave_valid  <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      wave_out    <= sample_s;
      wave_valid  <= en1_r;
      cycle_start <= wrap1_r;
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// Directed self-checking bench for wave_gen (PHASE_W=32, DATA_W=8).
module tb_wave_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] freq_word;
  logic [2:0]  wave_sel;
  logic [7:0]  duty;
  logic [7:0]  wave_out;
  logic        wave_valid;
  logic        cycle_start;

  int checks = 0;
  int errors = 0;

  wave_gen #(.PHASE_W(32), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .freq_word  (freq_word),
    .wave_sel   (wave_sel),
    .duty       (duty),
    .wave_out   (wave_out),
    .wave_valid (wave_valid),
    .cycle_start(cycle_start)
  );

  always #5 clk = ~clk;

  // Reference sample for 8-bit phase index p.
  function automatic int model(input int p, input int sel, input int dty);
    int x;
    int q;
    x = p % 128;
    case (sel)
      0: begin
        q = (x * (127 - x)) / 32;
        model = (p < 128) ? (128 + q) : (127 - q);
      end
      1: model = (p < 128) ? (2 * x) : (255 - 2 * x);
      2: model = p;
      3: model = (p < dty) ? 255 : 0;
      default: model = 128;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sample k of a run with freq_word = 0x01000000 started at p=0.
  task automatic chk_sample(input int k, input int sel, input int dty);
    int p;
    p = k % 256;
    chk($sformatf("out_k%0d", k), int'(wave_out), model(p, sel, dty));
    chk($sformatf("valid_k%0d", k), int'(wave_valid), 1);
    chk($sformatf("cs_k%0d", k), int'(cycle_start), (k != 0 && p == 0) ? 1 : 0);
  endtask

  // Reset, load wave_sel while idle, then run; returns with sample k=0 on the output.
  task automatic start_run(input int sel, input int dty, input logic [31:0] fw);
    rst = 1'b1; en = 1'b0; wave_sel = 3'(sel); duty = 8'(dty); freq_word = fw;
    tick();
    rst = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk("pre_valid", int'(wave_valid), 0);
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; freq_word = 32'd0; wave_sel = 3'd2; duty = 8'd0;
    tick(); tick();
    chk("rst_out", int'(wave_out), 0);
    chk("rst_valid", int'(wave_valid), 0);
    chk("rst_cs", int'(cycle_start), 0);

    // Sawtooth
    start_run(2, 0, 32'h0100_0000);
    for (int k = 0; k <= 256; k++) begin
      if (k > 0) tick();
      chk_sample(k, 2, 0);
    end

    // Triangle
    start_run(1, 0, 32'h0100_0000);
    for (int k = 0; k <= 257; k++) begin
      if (k > 0) tick();
      chk_sample(k, 1, 0);
      if (k == 127) chk("tri_127", int'(wave_out), 254);
      if (k == 128) chk("tri_128", int'(wave_out), 255);
      if (k == 255) chk("tri_255", int'(wave_out), 1);
    end

    // Sine
    start_run(0, 0, 32'h0100_0000);
    for (int k = 0; k <= 256; k++) begin
      if (k > 0) tick();
      chk_sample(k, 0, 0);
      chk("sine_range", (wave_out >= 8'd1 && wave_out <= 8'd254) ? 1 : 0, 1);
      if (k == 63)  chk("sine_63", int'(wave_out), 254);
      if (k == 127) chk("sine_127", int'(wave_out), 128);
      if (k == 128) chk("sine_128", int'(wave_out), 127);
      if (k == 191) chk("sine_191", int'(wave_out), 1);
    end

    // Square duty 64, then duty 0 takes effect within two cycles
    start_run(3, 64, 32'h0100_0000);
    for (int k = 0; k <= 256; k++) begin
      if (k > 0) tick();
      chk_sample(k, 3, 64);
    end
    duty = 8'd0;
    tick();
    chk("duty0_lat1", int'(wave_out), 255);
    tick();
    chk("duty0_lat2", int'(wave_out), 0);
    en = 1'b0;
    tick(); tick();
    chk("idle_valid", int'(wave_valid), 0);

    // freq_word = 0: static phase, never wraps
    start_run(2, 0, 32'h0000_0000);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      chk("static_out", int'(wave_out), 0);
      chk("static_cs", int'(cycle_start), 0);
      chk("static_valid", int'(wave_valid), 1);
    end

    // Waveform switches while running apply at wrap
    start_run(2, 0, 32'h0100_0000);
    for (int k = 0; k <= 520; k++) begin
      if (k > 0) tick();
      chk_sample(k, (k < 256) ? 2 : ((k < 512) ? 1 : 6), 0);
      if (k == 100) wave_sel = 3'd1;
      if (k == 300) wave_sel = 3'd6;
    end

    // Mid-period reset, then a downward sweep with a wrap on every step but the first
    rst = 1'b1;
    tick();
    chk("mrst_out", int'(wave_out), 0);
    chk("mrst_valid", int'(wave_valid), 0);
    chk("mrst_cs", int'(cycle_start), 0);
    rst = 1'b0; en = 1'b0; wave_sel = 3'd2;
    tick();
    chk("down_idle_valid", int'(wave_valid), 0);
    en = 1'b1; freq_word = 32'hFF00_0000;
    tick();
    chk("down_pre_valid", int'(wave_valid), 0);
    tick();
    for (int j = 0; j <= 20; j++) begin
      if (j > 0) tick();
      chk($sformatf("down_out_%0d", j), int'(wave_out), (256 - j) % 256);
      chk($sformatf("down_cs_%0d", j), int'(cycle_start), (j >= 2) ? 1 : 0);
      chk("down_valid", int'(wave_valid), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
